geofence_sched: RTL and testbench
=================================

Name: geofence_sched

Overview:
- Sequencing controller for the geofence datapath.
- Captures one object point followed by six receiver points from the X/Y stream.
- Orders the receivers counter-clockwise around receiver 0 with a bubble sort, then runs the six-edge containment test.
- All sign decisions are made by a single shared cross-product unit, driven over a req/ack handshake.
- Outputs a one-cycle valid pulse with is_inside; this is the top-level result interface of the geofence design.

Parameters:
- CW, 10, coordinate width of X, Y and all cross-product operands (unsigned).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- X  in  CW  point x coordinate, sampled in LOAD.
- Y  in  CW  point y coordinate, sampled in LOAD.
- cp_req  out  1  cross-product request.
- cp_x0, cp_y0  out  CW each  origin point P0.
- cp_x1, cp_y1  out  CW each  point P1.
- cp_x2, cp_y2  out  CW each  point P2. The unit evaluates (P1-P0)x(P2-P0).
- cp_ack  in  1  one-cycle pulse: result ready.
- cp_neg  in  1  result < 0; qualified by cp_ack only.
- valid  out  1  one-cycle result strobe.
- is_inside  out  1  containment result, meaningful when valid=1.

Behaviour:
- Reset, asynchronous:
  - FSM goes to LOAD with load counter 0.
  - valid=0, is_inside=0, cp_req=0, all cp_* operands 0.
  - Point registers are cleared.
  - Reset mid-operation aborts the group. No valid is produced for it, and any later cp_ack is ignored.
- FSM states: LOAD -> SORT -> TEST -> DONE -> LOAD.
- LOAD:
  - Samples X/Y on 7 consecutive rising edges, with counter 0..6.
  - Sample 0 is the object O; samples 1..6 go to R[0..5].
  - No input qualifier exists: every edge in LOAD is a sample.
  - The edge taking sample 6 moves the FSM to SORT.
- SORT:
  - Fixed bubble sort over R[1..5], pivot R[0].
  - Passes p=0..3, each with i=1..(4-p): 4+3+2+1 = 10 compares, always all executed.
  - Each compare sends P0=R[0], P1=R[i], P2=R[i+1].
  - On an ack with cp_neg=1, R[i] and R[i+1] are swapped at that edge.
  - The ack of the 10th compare moves the FSM to TEST.
- TEST:
  - For edge k=0..5, sends P0=R[k], P1=R[(k+1) mod 6], P2=O.
  - On an ack with cp_neg=1: is_inside is cleared and the FSM goes to DONE immediately (early exit).
  - If the ack for k=5 arrives with cp_neg=0: is_inside=1, then DONE.
  - A zero cross product (object on an edge or vertex) counts as inside.
- DONE:
  - Lasts exactly one cycle with valid=1; is_inside stays stable through it.
  - Next state is LOAD.
  - Sample 0 of the next group is taken on the first rising edge after the edge that leaves DONE.
  - is_inside holds its value until the next DONE or reset.
- Handshake:
  - cp_req and all operands are registered and held stable while cp_req=1.
  - cp_req falls on the edge that samples cp_ack=1.
  - cp_req is low for exactly one cycle between consecutive operations, so one operation takes L+1 cycles for ack latency L>=1.
  - The first request is raised in the first cycle of SORT or TEST.
  - cp_ack while cp_req=0 is ignored.
  - cp_ack is never generated in the same cycle cp_req rises.
- Latency, reset-free group:
  - 7 load cycles + 10 sort ops + up to 6 test ops + 1 DONE cycle.
  - Minimum at L=1 with all six tests executed: 7 + 16*2 + 1 = 40 cycles from sample 0 to valid inclusive.
- Widths: operands are passed unmodified. Sign and magnitude arithmetic (2*CW+3 bits signed) belongs to the cross-product unit.

Test Plan:
- Inside, in order:
  - O=(500,500); R=(600,500),(550,587),(450,587),(400,500),(450,413),(550,413); ack latency 1.
  - Expect 10 sort + 6 test requests, zero swaps, valid at cycle 40, is_inside=1.
- Shuffled receivers, object outside:
  - Same R set fed in shuffled order: (600,500),(450,413),(550,587),(400,500),(550,413),(450,587).
  - O=(700,700).
  - Expect sorted order to match the in-order case, is_inside=0, and fewer than 6 test requests (early exit).
- Object on a vertex: O=(600,500) with the in-order R. Two tests return zero -> is_inside=1.
- Variable ack latency: random 1..8 cycles. Check operands stable while cp_req=1, exactly one idle cycle between requests, and results identical to the first two scenarios.
- Reset during SORT: assert reset after the 4th ack.
  - Expect cp_req=0 and valid=0 asynchronously.
  - A stray cp_ack afterwards is ignored.
  - The next full group yields the correct result.
- Back-to-back groups: three objects streamed with no gap after each valid. Check the sample alignment of every group and the results 1, 0, 1.

Source files
------------

// File: rtl/geofence_sched.sv
// Sequencer that loads an object and six receivers, sorts the receivers CCW about R[0], then tests containment.
// Each cross-product op costs L+1 cycles. The shared unit stalls the FSM through req/ack, and valid is a single-cycle pulse.
module geofence_sched #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          cp_req,
    output logic [CW-1:0] cp_x0,
    output logic [CW-1:0] cp_y0,
    output logic [CW-1:0] cp_x1,
    output logic [CW-1:0] cp_y1,
    output logic [CW-1:0] cp_x2,
    output logic [CW-1:0] cp_y2,
    input  logic          cp_ack,
    input  logic          cp_neg,
    output logic          valid,
    output logic          is_inside
);

    typedef enum logic [1:0] {LOAD, SORT, TEST, DONE} state_t;

    state_t        state;
    logic [2:0]    load_cnt;
    logic [1:0]    pass;
    logic [2:0]    idx;          // sort compare index i, or test edge k
    logic [CW-1:0] ox, oy;
    logic [CW-1:0] rx [6];
    logic [CW-1:0] ry [6];

    logic [2:0] idx_p1;
    logic [2:0] idx_wrap;
    logic [2:0] last_i;

    assign idx_p1   = idx + 3'd1;
    assign idx_wrap = (idx == 3'd5) ? 3'd0 : idx_p1;
    assign last_i   = 3'd4 - {1'b0, pass};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            load_cnt  <= 3'd0;
            pass      <= 2'd0;
            idx       <= 3'd0;
            ox        <= '0;
            oy        <= '0;
            for (int j = 0; j < 6; j++) begin
                rx[j] <= '0;
                ry[j] <= '0;
            end
            cp_req    <= 1'b0;
            cp_x0     <= '0;
            cp_y0     <= '0;
            cp_x1     <= '0;
            cp_y1     <= '0;
            cp_x2     <= '0;
            cp_y2     <= '0;
            valid     <= 1'b0;
            is_inside <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                LOAD: begin
                    if (load_cnt == 3'd0) begin
                        ox <= X;
                        oy <= Y;
                    end else begin
                        rx[load_cnt - 3'd1] <= X;
                        ry[load_cnt - 3'd1] <= Y;
                    end
                    if (load_cnt == 3'd6) begin
                        load_cnt <= 3'd0;
                        pass     <= 2'd0;
                        idx      <= 3'd1;
                        state    <= SORT;
                    end else begin
                        load_cnt <= load_cnt + 3'd1;
                    end
                end
                SORT: begin
                    // A request is issued whenever cp_req is low, which gives the one idle cycle between ops.
                    if (!cp_req) begin
                        cp_req <= 1'b1;
                        cp_x0  <= rx[0];
                        cp_y0  <= ry[0];
                        cp_x1  <= rx[idx];
                        cp_y1  <= ry[idx];
                        cp_x2  <= rx[idx_p1];
                        cp_y2  <= ry[idx_p1];
                    end else if (cp_ack) begin
                        cp_req <= 1'b0;
                        if (cp_neg) begin
                            rx[idx]    <= rx[idx_p1];
                            ry[idx]    <= ry[idx_p1];
                            rx[idx_p1] <= rx[idx];
                            ry[idx_p1] <= ry[idx];
                        end
                        if (idx == last_i) begin
                            if (pass == 2'd3) begin
                                idx   <= 3'd0;
                                state <= TEST;
                            end else begin
                                pass <= pass + 2'd1;
                                idx  <= 3'd1;
                            end
                        end else begin
                            idx <= idx_p1;
                        end
                    end
                end
                TEST: begin
                    if (!cp_req) begin
                        cp_req <= 1'b1;
                        cp_x0  <= rx[idx];
                        cp_y0  <= ry[idx];
                        cp_x1  <= rx[idx_wrap];
                        cp_y1  <= ry[idx_wrap];
                        cp_x2  <= ox;
                        cp_y2  <= oy;
                    end else if (cp_ack) begin
                        cp_req <= 1'b0;
                        // A zero cross product keeps the object inside; only a strictly negative one exits.
                        if (cp_neg) begin
                            is_inside <= 1'b0;
                            valid     <= 1'b1;
                            state     <= DONE;
                        end else if (idx == 3'd5) begin
                            is_inside <= 1'b1;
                            valid     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx <= idx_wrap;
                        end
                    end
                end
                DONE: begin
                    state <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_sched.sv
// Bench for geofence_sched: a cross-product unit model with variable ack latency,
// plus a reference that ranks receivers by angular order and tests containment.
module tb_geofence_sched;

    logic       clk;
    logic       reset;
    logic [9:0] X, Y;
    logic       cp_req;
    logic [9:0] cp_x0, cp_y0, cp_x1, cp_y1, cp_x2, cp_y2;
    logic       cp_ack, cp_neg;
    logic       valid, is_inside;

    geofence_sched #(.CW(10)) dut (
        .clk(clk), .reset(reset), .X(X), .Y(Y),
        .cp_req(cp_req),
        .cp_x0(cp_x0), .cp_y0(cp_y0), .cp_x1(cp_x1), .cp_y1(cp_y1),
        .cp_x2(cp_x2), .cp_y2(cp_y2),
        .cp_ack(cp_ack), .cp_neg(cp_neg),
        .valid(valid), .is_inside(is_inside)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [59:0] ops_now;
    assign ops_now = {cp_x0, cp_y0, cp_x1, cp_y1, cp_x2, cp_y2};

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus for the next group, and the reference expectations derived from it.
    logic [9:0] g_rx [6];
    logic [9:0] g_ry [6];
    logic [9:0] g_ox, g_oy;
    logic [9:0] exp_srx [6];
    logic [9:0] exp_sry [6];
    logic [9:0] exp_ox, exp_oy;
    bit         exp_in;
    int         exp_tests;

    // Cross-product unit state.
    int          lat_fixed = 1;
    int          ops_total = 0;
    int          lat_total = 0;
    int          grp_base = 0;
    int          hold = 0;
    int          cur_lat = 1;
    int          idle_n = 0;
    bit          req_prev = 0;
    bit          stray_on = 0;
    logic [59:0] prev_ops = '0;

    int bx [6] = '{1000, 500, -500, -1000, -500, 500};
    int by [6] = '{0, 866, 866, 0, -866, -866};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int xprod(int x0, int y0, int x1, int y1, int x2, int y2);
        return (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
    endfunction

    // One clock: wait for the edge, then act as the cross-product unit and watch the handshake.
    task automatic tick();
        int n, k, kn;
        @(posedge clk);
        #1;
        cp_ack = 1'b0;
        cp_neg = 1'b0;
        if (stray_on) begin
            cp_ack = 1'b1;
            cp_neg = 1'b1;
        end
        if (cp_req) begin
            n = ops_total - grp_base;
            if (req_prev) begin
                chk("op_stable", ops_now, prev_ops);
            end else begin
                if (n > 0) chk("req_gap", idle_n, 1);
                if (n < 10) begin
                    chk("sort_p0", {cp_x0, cp_y0}, {exp_srx[0], exp_sry[0]});
                end else if (n < 16) begin
                    k  = n - 10;
                    kn = (k + 1) % 6;
                    chk("test_ops", ops_now,
                        {exp_srx[k], exp_sry[k], exp_srx[kn], exp_sry[kn], exp_ox, exp_oy});
                end
                hold    = 0;
                cur_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
            end
            hold++;
            if (hold == cur_lat) begin
                cp_ack    = 1'b1;
                cp_neg    = xprod(cp_x0, cp_y0, cp_x1, cp_y1, cp_x2, cp_y2) < 0;
                ops_total++;
                lat_total += cur_lat;
            end
            idle_n = 0;
        end else begin
            idle_n++;
        end
        req_prev = cp_req;
        prev_ops = ops_now;
    endtask

    // Stream one group (O then R[0..5]) and check the result. Returns just after the edge leaving DONE.
    task automatic run_group(input int lat, input int abort_at, input bit stray);
        int rank, cyc, n, lat_base, c;
        // Reference: each receiver's slot is one plus the number of receivers clockwise of it about R[0].
        exp_srx[0] = g_rx[0];
        exp_sry[0] = g_ry[0];
        for (int j = 1; j < 6; j++) begin
            rank = 1;
            for (int m = 1; m < 6; m++)
                if (m != j && xprod(g_rx[0], g_ry[0], g_rx[m], g_ry[m], g_rx[j], g_ry[j]) > 0)
                    rank++;
            exp_srx[rank] = g_rx[j];
            exp_sry[rank] = g_ry[j];
        end
        exp_ox    = g_ox;
        exp_oy    = g_oy;
        exp_in    = 1'b1;
        exp_tests = 6;
        for (int k = 0; k < 6; k++) begin
            c = xprod(exp_srx[k], exp_sry[k], exp_srx[(k+1)%6], exp_sry[(k+1)%6], g_ox, g_oy);
            if (exp_in && c < 0) begin
                exp_in    = 1'b0;
                exp_tests = k + 1;
            end
        end
        lat_fixed = lat;
        grp_base  = ops_total;
        lat_base  = lat_total;
        stray_on  = stray;
        for (int s = 0; s < 7; s++) begin
            if (s == 0) begin
                X = g_ox;
                Y = g_oy;
            end else begin
                X = g_rx[s-1];
                Y = g_ry[s-1];
            end
            tick();
            stray_on = 1'b0;
        end
        cyc = 8;
        while (cyc < 300 && !valid) begin
            n = ops_total - grp_base;
            if (abort_at > 0 && n >= abort_at && cp_req && !cp_ack) begin
                #1 reset = 1'b0;
                #1;
                chk("abort_req", cp_req, 0);
                chk("abort_valid", valid, 0);
                chk("abort_ops", ops_now, 0);
                tick();
                #1 reset = 1'b1;
                return;
            end
            tick();
            cyc++;
        end
        if (!valid) begin
            chk("valid_timeout", cyc, 0);
            #1 reset = 1'b0;
            tick();
            #1 reset = 1'b1;
            return;
        end
        n = ops_total - grp_base;
        if (lat > 0) chk("latency", cyc, 8 + (10 + exp_tests) * (lat + 1));
        else         chk("latency", cyc, 8 + n + (lat_total - lat_base));
        chk("is_inside", is_inside, exp_in);
        chk("op_count", n, 10 + exp_tests);
        tick();
        chk("valid_pulse", valid, 0);
        chk("inside_hold", is_inside, exp_in);
    endtask

    task automatic set_inorder();
        g_rx = '{600, 550, 450, 400, 450, 550};
        g_ry = '{500, 587, 587, 500, 413, 413};
    endtask

    task automatic set_shuffled();
        g_rx = '{600, 450, 550, 400, 550, 450};
        g_ry = '{500, 413, 587, 500, 413, 587};
    endtask

    initial begin
        int cx, cy, r, m;
        logic [9:0] t;
        reset  = 1'b0;
        X      = '0;
        Y      = '0;
        cp_ack = 1'b0;
        cp_neg = 1'b0;
        #3;
        chk("rst_valid", valid, 0);
        chk("rst_inside", is_inside, 0);
        chk("rst_req", cp_req, 0);
        chk("rst_ops", ops_now, 0);
        tick();
        #1 reset = 1'b1;

        set_inorder();  g_ox = 500; g_oy = 500; run_group(1, 0, 0);
        set_shuffled(); g_ox = 700; g_oy = 700; run_group(1, 0, 0);
        set_inorder();  g_ox = 600; g_oy = 500; run_group(1, 0, 0);

        set_inorder();  g_ox = 500; g_oy = 500; run_group(0, 0, 0);
        set_shuffled(); g_ox = 700; g_oy = 700; run_group(0, 0, 0);
        set_shuffled(); g_ox = 500; g_oy = 500; run_group(0, 0, 0);

        set_inorder();  g_ox = 500; g_oy = 500; run_group(3, 4, 0);
        set_inorder();  g_ox = 500; g_oy = 500; run_group(1, 0, 1);

        set_inorder();  g_ox = 500; g_oy = 500; run_group(1, 0, 0);
        set_inorder();  g_ox = 700; g_oy = 700; run_group(1, 0, 0);
        set_inorder();  g_ox = 520; g_oy = 480; run_group(1, 0, 0);

        for (int gi = 0; gi < 25; gi++) begin
            cx = $urandom_range(250, 750);
            cy = $urandom_range(250, 750);
            r  = $urandom_range(40, 110);
            for (int j = 0; j < 6; j++) begin
                g_rx[j] = 10'(cx + (bx[j] * r) / 1000);
                g_ry[j] = 10'(cy + (by[j] * r) / 1000);
            end
            for (int j = 5; j > 0; j--) begin
                m = $urandom_range(0, j);
                t = g_rx[j]; g_rx[j] = g_rx[m]; g_rx[m] = t;
                t = g_ry[j]; g_ry[j] = g_ry[m]; g_ry[m] = t;
            end
            g_ox = 10'(cx - 2 * r + int'($urandom_range(0, 4 * r)));
            g_oy = 10'(cy - 2 * r + int'($urandom_range(0, 4 * r)));
            run_group(0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
